// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction ROM and
// buffers {pc, instr} in a small FIFO that feeds decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  misalign_fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP      = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             fault_q, fault_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];

    logic full;
    logic pop;
    logic push;
    logic take_redirect;

    assign imem_addr      = fetch_pc_q[ADDR_WIDTH-1:0];
    assign misalign_fault = fault_q;

    // Outputs depend only on registered FIFO state, never on out_ready.
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : NOP;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;

    assign full          = (count_q == FULL_CNT);
    assign pop           = out_valid & out_ready;
    assign push          = !redirect_valid & !fault_q & (!full | pop);
    assign take_redirect = redirect_valid & !fault_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (take_redirect) begin
            // Flush wins over any simultaneous pop; a misaligned target freezes fetch.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end else begin
                fetch_pc_d = redirect_pc;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, async reset,
// PC wrap-around instance, and a randomized run against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_fault;

    logic        rst2;
    logic [7:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic        misalign_fault2;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'h1000_0000 + 32'(a >> 2);
    endfunction

    assign imem_rdata  = rom_word(imem_addr);
    assign imem_rdata2 = rom_word(imem_addr2);

    instruction_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .misalign_fault(misalign_fault)
    );

    instruction_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .misalign_fault(misalign_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, advance one clock, then sample 1 time unit later.
    task automatic step(input logic r, input logic v, input logic [31:0] p, input logic rdy);
        rst            = r;
        redirect_valid = v;
        redirect_pc    = p;
        out_ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic        m_fault;

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endtask

    // One clock edge of the fetch unit expressed as queue operations.
    task automatic model_edge(input logic r, input logic v, input logic [31:0] p, input logic rdy);
        if (r) begin
            model_reset();
        end else if (v) begin
            if (!m_fault) begin
                mq.delete();
                if (p[1:0] != 2'b00) m_fault = 1'b1;
                else                 m_pc    = p;
            end
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (!m_fault && mq.size() < 2) begin
                mq.push_back('{pc: m_pc, instr: rom_word(m_pc[7:0])});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model(input int cyc);
        logic        ev;
        logic [31:0] epc, ein;
        ev  = (mq.size() > 0);
        epc = ev ? mq[0].pc    : 32'h0;
        ein = ev ? mq[0].instr : NOP;
        check($sformatf("rnd%0d out_valid", cyc), {31'b0, out_valid}, {31'b0, ev});
        check($sformatf("rnd%0d out_pc", cyc), out_pc, epc);
        check($sformatf("rnd%0d out_instr", cyc), out_instr, ein);
        check($sformatf("rnd%0d fault", cyc), {31'b0, misalign_fault}, {31'b0, m_fault});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [31:0] rp;
        logic        rv, rr;

        // stream, backpressure, redirect, redirect+pop on full, misaligned
        vt[0]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 1'b0};
        vt[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 1'b0};
        vt[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b0};
        vt[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0};
        vt[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0};
        vt[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0};
        vt[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0};
        vt[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 1'b0};
        vt[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 1'b0};
        vt[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b0};
        vt[10] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 1'b0};
        vt[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 1'b0};
        vt[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h40, 1'b0};
        vt[13] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h00, 1'b0};
        vt[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 1'b0};
        vt[15] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h84, 1'b0};
        vt[16] = '{1'b1, 32'h42, 1'b1, 1'b0, 32'h00, 1'b1};
        vt[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1};
        vt[18] = '{1'b1, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1};
        vt[19] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 1'b1};

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        rst2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", {31'b0, out_valid}, 32'h0);
        check("rst out_instr", out_instr, NOP);
        check("rst out_pc", out_pc, 32'h0);
        check("rst fault", {31'b0, misalign_fault}, 32'h0);
        check("rst imem_addr", {24'b0, imem_addr}, 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, vt[i].rv, vt[i].rpc, vt[i].rdy);
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ev});
            check($sformatf("vec%0d out_pc", i), out_pc, vt[i].ev ? vt[i].epc : 32'h0);
            check($sformatf("vec%0d out_instr", i), out_instr,
                  vt[i].ev ? rom_word(vt[i].epc[7:0]) : NOP);
            check($sformatf("vec%0d fault", i), {31'b0, misalign_fault}, {31'b0, vt[i].ef});
        end

        // Asynchronous reset mid-cycle clears the fault at once, then fetch restarts at 0.
        #2;
        rst = 1'b1;
        #1;
        check("async rst fault", {31'b0, misalign_fault}, 32'h0);
        check("async rst valid", {31'b0, out_valid}, 32'h0);
        check("async rst imem_addr", {24'b0, imem_addr}, 32'h0);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("restart valid", {31'b0, out_valid}, 32'h1);
        check("restart pc", out_pc, 32'h0);
        check("restart instr", out_instr, 32'h1000_0000);

        // PC wrap instance.
        check("wrap rst imem_addr", {24'b0, imem_addr2}, 32'hF8);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("wrap pc0", out_pc2, 32'hFFFF_FFF8);
        check("wrap instr0", out_instr2, rom_word(8'hF8));
        check("wrap imem_addr1", {24'b0, imem_addr2}, 32'hFC);
        @(posedge clk); #1;
        check("wrap pc1", out_pc2, 32'hFFFF_FFFC);
        check("wrap imem_addr2", {24'b0, imem_addr2}, 32'h00);
        @(posedge clk); #1;
        check("wrap pc2", out_pc2, 32'h0000_0000);
        check("wrap instr2", out_instr2, rom_word(8'h00));
        check("wrap valid", {31'b0, out_valid2}, 32'h1);

        // Randomized run against the reference model.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            logic rr_rst;
            rr_rst = ((c % 250) == 249);
            rv = ($urandom_range(0, 9) == 0);
            rp = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 3) == 0) rp[31:8] = 24'($urandom);
            if ($urandom_range(0, 40) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            rr = ($urandom_range(0, 3) != 0);
            model_edge(rr_rst, rv, rp, rr);
            step(rr_rst, rv, rp, rr);
            check_model(c);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
